// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
//   Three-port arbiter in front of a single-port unified memory for a small
//   MIPS core: data port (MEM stage), instruction fetch, and loader/debug.
//   Each access takes IDLE -> ISSUE -> RESP. The request is sampled in IDLE,
//   mem_en is high in ISSUE, and the owner's ack is high in RESP.
//   Priority is D > I > L while running and L > D > I while halted.
//
// Optional feature (macro MEM_ARB_STARVE_GUARD_EN):
//   A per-port 2-bit count of arbitrations lost while requesting. A port
//   whose count has reached 3 wins the next arbitration.
//
// Ports:
//   clk1, rst                      clock, synchronous active-high reset
//   d_req/d_we/d_addr/d_wdata      data-port request        -> d_ack
//   i_req/i_addr                   fetch request (read only) -> i_ack
//   l_req/l_we/l_addr/l_wdata      loader request            -> l_ack
//   rdata                          read data, valid with any ack
//   halted                         processor halted flag (changes priority)
//   mem_en/mem_we/mem_addr/mem_wdata  memory command
//   mem_rdata                      memory read data, one cycle after mem_en
//   busy, owner                    access in flight; owner 0=D 1=I 2=L 3=none
module mips_mem_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ack,
  output logic [DW-1:0] rdata,
  input  logic          halted,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [1:0]    owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic [1:0] {
    PORT_D    = 2'd0,
    PORT_I    = 2'd1,
    PORT_L    = 2'd2,
    PORT_NONE = 2'd3
  } port_t;

  state_t        state;
  port_t         owner_q;
  port_t         grant;
  logic [2:0]    req_vec;
  logic [2:0]    cand;
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [DW-1:0] sel_wdata;

  assign req_vec = {l_req, i_req, d_req};
  assign owner   = owner_q;

  // mem_rdata only becomes valid in RESP, the same cycle the ack is shown,
  // so rdata passes it through there and holds the captured copy otherwise.
  assign rdata = (state == RESP) ? mem_rdata : rdata_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [1:0] d_cnt;
  logic [1:0] i_cnt;
  logic [1:0] l_cnt;
  logic [2:0] starved;

  assign starved = {l_req && (l_cnt == 2'd3),
                    i_req && (i_cnt == 2'd3),
                    d_req && (d_cnt == 2'd3)};

  function automatic logic [1:0] next_cnt(input logic [1:0] cnt,
                                          input logic       req,
                                          input logic       won);
    if (!req || won) return '0;
    if (cnt == 2'd3) return cnt;
    return cnt + 2'd1;
  endfunction

  always_ff @(posedge clk1) begin
    if (rst) begin
      d_cnt <= '0;
      i_cnt <= '0;
      l_cnt <= '0;
    end else if (state == IDLE && grant != PORT_NONE) begin
      d_cnt <= next_cnt(d_cnt, d_req, grant == PORT_D);
      i_cnt <= next_cnt(i_cnt, i_req, grant == PORT_I);
      l_cnt <= next_cnt(l_cnt, l_req, grant == PORT_L);
    end else begin
      if (!d_req) d_cnt <= '0;
      if (!i_req) i_cnt <= '0;
      if (!l_req) l_cnt <= '0;
    end
  end
`endif

  // Starved ports, when any exist, replace the full request set; the normal
  // priority order then resolves ties among them.
  always_comb begin
    cand = req_vec;
`ifdef MEM_ARB_STARVE_GUARD_EN
    if (|starved) cand = starved;
`endif
    grant = PORT_NONE;
    if (halted) begin
      if (cand[2])      grant = PORT_L;
      else if (cand[0]) grant = PORT_D;
      else if (cand[1]) grant = PORT_I;
    end else begin
      if (cand[0])      grant = PORT_D;
      else if (cand[1]) grant = PORT_I;
      else if (cand[2]) grant = PORT_L;
    end
  end

  always_comb begin
    sel_addr  = d_addr;
    sel_we    = d_we;
    sel_wdata = d_wdata;
    case (grant)
      PORT_I: begin
        sel_addr  = i_addr;
        sel_we    = 1'b0;
        sel_wdata = '0;
      end
      PORT_L: begin
        sel_addr  = l_addr;
        sel_we    = l_we;
        sel_wdata = l_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= IDLE;
      owner_q   <= PORT_NONE;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      d_ack     <= 1'b0;
      i_ack     <= 1'b0;
      l_ack     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != PORT_NONE) begin
            state     <= ISSUE;
            owner_q   <= grant;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        ISSUE: begin
          state  <= RESP;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          d_ack  <= (owner_q == PORT_D);
          i_ack  <= (owner_q == PORT_I);
          l_ack  <= (owner_q == PORT_L);
        end
        RESP: begin
          state   <= IDLE;
          owner_q <= PORT_NONE;
          busy    <= 1'b0;
          d_ack   <= 1'b0;
          i_ack   <= 1'b0;
          l_ack   <= 1'b0;
          rdata_q <= mem_rdata;
        end
        default: begin
          state   <= IDLE;
          owner_q <= PORT_NONE;
          busy    <= 1'b0;
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter
//   Directed bench for mips_mem_arbiter with a synchronous 1024-word memory
//   model. Inputs change and outputs are observed on the falling clock edge.
module tb_mips_mem_arbiter;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        d_req, d_we, i_req, l_req, l_we, halted;
  logic [9:0]  d_addr, i_addr, l_addr;
  logic [31:0] d_wdata, l_wdata;
  logic        d_ack, i_ack, l_ack;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic [1:0]  owner;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:1023];
  logic        init_done = 1'b0;

  always #5 clk1 = ~clk1;

  always @(posedge clk1) begin
    if (!init_done) begin
      mem[0]    <= 32'h20010001;
      mem[3]    <= 32'h8c220004;
      mem[5]    <= 32'h2801000a;
      mem[8]    <= 32'hdeadbeef;
      mem[1023] <= 32'h00000000;
      init_done <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  mips_mem_arbiter #(.AW(10), .DW(32)) dut (
    .clk1(clk1), .rst(rst),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_ack(l_ack),
    .rdata(rdata), .halted(halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  task automatic step();
    @(negedge clk1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    i_req = 0; i_addr = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    halted = 0;
    step(); step();
    checks++; if ({d_ack, i_ack, l_ack} !== 3'b000) begin errors++; $display("FAIL reset_acks got %b exp 000", {d_ack, i_ack, l_ack}); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_en_we got %b exp 00", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (owner !== 2'd3) begin errors++; $display("FAIL reset_owner got %0d exp 3", owner); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_fetch();
    i_req = 1; i_addr = 10'd5;
    step();
    checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("FAIL fetch_issue_en_we got %b exp 10", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 10'd5) begin errors++; $display("FAIL fetch_issue_addr got %0d exp 5", mem_addr); end
    checks++; if (owner !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL fetch_issue_owner got owner=%0d busy=%b exp 1/1", owner, busy); end
    checks++; if (i_ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack got %b exp 0", i_ack); end
    step();
    checks++; if ({d_ack, i_ack, l_ack} !== 3'b010) begin errors++; $display("FAIL fetch_ack got %b exp 010", {d_ack, i_ack, l_ack}); end
    checks++; if (rdata !== 32'h2801000a) begin errors++; $display("FAIL fetch_rdata got %h exp 2801000a", rdata); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL fetch_resp_mem_en got %b exp 0", mem_en); end
    i_req = 0;
    step();
    checks++; if (i_ack !== 1'b0 || busy !== 1'b0 || owner !== 2'd3) begin errors++; $display("FAIL fetch_idle got ack=%b busy=%b owner=%0d exp 0/0/3", i_ack, busy, owner); end
    checks++; if (rdata !== 32'h2801000a) begin errors++; $display("FAIL fetch_rdata_hold got %h exp 2801000a", rdata); end
  endtask

  task automatic test_collision();
    int d_cyc = -1;
    int i_cyc = -1;
    int both = 0;
    logic [31:0] d_data = '0;
    logic [31:0] i_data = '0;
    halted = 0;
    d_req = 1; d_we = 0; d_addr = 10'd3;
    i_req = 1; i_addr = 10'd0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL collision_owner got %0d exp 0", owner); end
      end
      if (d_ack && i_ack) both++;
      if (d_ack) begin d_cyc = c; d_data = rdata; d_req = 0; end
      if (i_ack) begin i_cyc = c; i_data = rdata; i_req = 0; end
    end
    d_req = 0; i_req = 0;
    checks++; if (d_cyc != 2) begin errors++; $display("FAIL collision_d_cycle got %0d exp 2", d_cyc); end
    checks++; if (i_cyc != 5) begin errors++; $display("FAIL collision_i_cycle got %0d exp 5", i_cyc); end
    checks++; if (both != 0) begin errors++; $display("FAIL collision_double_ack got %0d exp 0", both); end
    checks++; if (d_data !== 32'h8c220004 || i_data !== 32'h20010001) begin errors++; $display("FAIL collision_rdata got %h/%h exp 8c220004/20010001", d_data, i_data); end
  endtask

  task automatic test_halted_load();
    int l_cyc = -1;
    int d_cyc = -1;
    logic [31:0] l_data = '0;
    halted = 1;
    l_req = 1; l_we = 1; l_addr = 10'd8; l_wdata = 32'hfc000000;
    d_req = 1; d_we = 0; d_addr = 10'd3;
    step();
    checks++; if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 10'd8) begin errors++; $display("FAIL load_issue got en/we=%b addr=%0d exp 11/8", {mem_en, mem_we}, mem_addr); end
    checks++; if (mem_wdata !== 32'hfc000000 || owner !== 2'd2) begin errors++; $display("FAIL load_issue_data got %h owner=%0d exp fc000000/2", mem_wdata, owner); end
    for (int c = 2; c <= 8; c++) begin
      step();
      if (l_ack) begin l_cyc = c; l_data = rdata; l_req = 0; l_we = 0; end
      if (d_ack) begin d_cyc = c; d_req = 0; end
    end
    checks++; if (l_cyc != 2 || d_cyc != 5) begin errors++; $display("FAIL load_ack_cycles got l=%0d d=%0d exp 2/5", l_cyc, d_cyc); end
    checks++; if (l_data !== 32'hdeadbeef) begin errors++; $display("FAIL load_write_rdata got %h exp deadbeef", l_data); end
    checks++; if (mem[8] !== 32'hfc000000) begin errors++; $display("FAIL load_mem_written got %h exp fc000000", mem[8]); end
    halted = 0;
  endtask

  task automatic test_reset_mid();
    d_req = 1; d_we = 0; d_addr = 10'd3;
    step();
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_issue got %b exp 1", mem_en); end
    rst = 1;
    step();
    checks++; if (d_ack !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_abandon got ack=%b en=%b exp 0/0", d_ack, mem_en); end
    checks++; if (busy !== 1'b0 || owner !== 2'd3 || rdata !== 32'd0 || mem_addr !== 10'd0) begin errors++; $display("FAIL rstmid_values got busy=%b owner=%0d rdata=%h addr=%0d exp 0/3/0/0", busy, owner, rdata, mem_addr); end
    rst = 0;
    step();
    checks++; if (mem_en !== 1'b1 || d_ack !== 1'b0) begin errors++; $display("FAIL rstmid_regrant got en=%b ack=%b exp 1/0", mem_en, d_ack); end
    step();
    checks++; if (d_ack !== 1'b1 || rdata !== 32'h8c220004) begin errors++; $display("FAIL rstmid_ack got ack=%b rdata=%h exp 1/8c220004", d_ack, rdata); end
    d_req = 0;
    step();
  endtask

  task automatic test_back_to_back();
    d_req = 1; d_we = 1; d_addr = 10'd1023; d_wdata = 32'ha5a5a5a5;
    step();
    checks++; if (mem_addr !== 10'd1023 || mem_we !== 1'b1) begin errors++; $display("FAIL b2b_write_issue got addr=%0d we=%b exp 1023/1", mem_addr, mem_we); end
    step();
    checks++; if (d_ack !== 1'b1) begin errors++; $display("FAIL b2b_write_ack got %b exp 1", d_ack); end
    d_we = 0;
    step();
    checks++; if (d_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_gap got ack=%b busy=%b exp 0/0", d_ack, busy); end
    step();
    checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("FAIL b2b_read_issue got %b exp 10", {mem_en, mem_we}); end
    step();
    checks++; if (d_ack !== 1'b1 || rdata !== 32'ha5a5a5a5) begin errors++; $display("FAIL b2b_readback got ack=%b rdata=%h exp 1/a5a5a5a5", d_ack, rdata); end
    d_req = 0;
    step();
  endtask

  task automatic test_starvation();
    int grants = 0;
    int i_grant = 0;
    d_req = 1; d_we = 0; d_addr = 10'd3;
    i_req = 1; i_addr = 10'd5;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int c = 1; c <= 30 && i_grant == 0; c++) begin
      step();
      if (d_ack) grants++;
      if (i_ack) begin grants++; i_grant = grants; i_req = 0; d_req = 0; end
    end
    checks++; if (i_grant < 1 || i_grant > 4) begin errors++; $display("FAIL starve_guard_grant got %0d exp 1..4", i_grant); end
`else
    for (int c = 1; c <= 15; c++) begin
      step();
      if (d_ack) grants++;
      if (i_ack) i_grant++;
    end
    checks++; if (i_grant != 0) begin errors++; $display("FAIL starve_fixed_i_grants got %0d exp 0", i_grant); end
    checks++; if (grants != 5) begin errors++; $display("FAIL starve_fixed_d_grants got %0d exp 5", grants); end
`endif
    d_req = 0; i_req = 0;
    step(); step(); step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_collision();
    test_halted_load();
    test_reset_mid();
    test_back_to_back();
    test_starvation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
